vpp_multi_ch: RTL and testbench
===============================

// Module: vpp_multi_ch
// PURPOSE
//   Multi-channel windowed peak detector for the Measure library: per channel, tracks max/min over a
//   runtime-selectable window of N valid samples and publishes max, min and vpp once per window.
//   Sits after the ADC capture stage on clk_fs; results feed the display/UART readout via irq.
// PARAMETERS
//   data_bit_width  12    sample width per channel
//   channels        2     number of channels measured in parallel
//   points_max      4096  largest window; CNT_W = $clog2(points_max+1)
//   signed_mode     0     0: samples unsigned; 1: samples two's complement
// PORTS
//   clk_fs     in   1                  sample clock
//   rst_n      in   1                  asynchronous active-low reset
//   data_valid in   1                  data_u qualifier; only valid cycles count
//   data_u     in   channels*W         channel k at bits [k*W +: W], W = data_bit_width
//   points     in   CNT_W              window length N; sampled at window start only
//   clear      in   1                  sync abort: discard current window, restart
//   irq_clr    in   1                  clears irq
//   max        out  channels*W         last completed window maximum per channel
//   min        out  channels*W         last completed window minimum per channel
//   vpp        out  channels*(W+1)     max-min per channel, unsigned, W+1 bits (no overflow)
//   done       out  1                  1-cycle pulse: results updated
//   irq        out  1                  sticky result-ready flag
//   cnt        out  CNT_W              valid samples taken in current window
// BEHAVIOUR
//   - Reset: all outputs 0, internal max/min regs 0, cnt 0, N_lat = clamp(points) on first window.
//   - Window start (cnt==0 and data_valid): N_lat <= clamp(points); per-channel max_r=min_r=sample.
//     clamp: points<2 -> 2; points>points_max -> points_max.
//   - Mid window (data_valid, 0<cnt<N_lat-1): max_r/min_r fold sample (signed compare if signed_mode).
//   - Last sample (data_valid, cnt==N_lat-1): final fold INCLUDES this sample; next cycle max/min/vpp
//     update, done=1 for one cycle, cnt wraps to 0. Latency: results valid 1 clk after last sample.
//   - data_valid=0: no state change; gaps of any length allowed inside a window.
//   - vpp = max - min computed in W+1 bits after sign-extension (signed) or zero-extension (unsigned).
//   - irq: set on done; cleared by irq_clr; set and clear same cycle -> set wins.
//   - clear: cnt<=0, fold regs discarded, published max/min/vpp/irq retained; clear with last sample
//     same cycle -> clear wins, no done. clear has priority over data_valid.
//   - points change mid-window has no effect until next window start.
//   - Async reset mid-window: immediate return to reset values, no done.
// CONFIGURATION
//   VPP_MEAN_EN defined: adds output  sum  out  channels*(W+CNT_W) window sample sum per channel
//     (signed accumulate if signed_mode), published with max/min on done; reset 0; cleared by clear.
//   VPP_MEAN_EN undefined: no sum port, no accumulators; all other behaviour identical.
// TESTING
//   1. W=12,ch=2,points=4; ch0 feeds 5,9,1,7, ch1 3,3,3,3 -> done once; ch0 max=9 min=1 vpp=8, ch1 vpp=0.
//   2. Last-sample fold: points=4, ch0 feeds 2,2,2,4095 -> max=4095 vpp=4093 (last sample counted).
//   3. data_valid toggled 1/0 every cycle, points=3 -> done 1 clk after 3rd valid sample, cnt holds in gaps.
//   4. signed_mode=1, ch0 feeds -2048,2047 (points=2) -> min=0x800 max=0x7FF vpp=4095 (13 bits).
//   5. points=0 -> window of 2; points changed 4->8 mid-window -> current window ends after 4 samples.
//   6. clear on last sample with irq_clr -> no done, irq=0, outputs unchanged; VPP_MEAN_EN: 1,2,3,4 -> sum=10.

Source files
------------

// File: rtl/vpp_multi_ch.sv
// Multi-channel windowed max/min/vpp detector with a runtime window length.
// Define VPP_MEAN_EN to add the per-channel window sum output.
module vpp_multi_ch #(
  parameter int data_bit_width = 12,
  parameter int channels       = 2,
  parameter int points_max     = 4096,
  parameter bit signed_mode    = 1'b0,
  localparam int W     = data_bit_width,
  localparam int CNT_W = $clog2(points_max + 1),
  localparam int SW    = W + CNT_W
) (
  input  logic                      clk_fs,
  input  logic                      rst_n,
  input  logic                      data_valid,
  input  logic [channels*W-1:0]     data_u,
  input  logic [CNT_W-1:0]          points,
  input  logic                      clear,
  input  logic                      irq_clr,
  output logic [channels*W-1:0]     max,
  output logic [channels*W-1:0]     min,
  output logic [channels*(W+1)-1:0] vpp,
`ifdef VPP_MEAN_EN
  output logic [channels*SW-1:0]    sum,
`endif
  output logic                      done,
  output logic                      irq,
  output logic [CNT_W-1:0]          cnt
);

  localparam logic [CNT_W-1:0] PMAX = CNT_W'(points_max);
  localparam logic [CNT_W-1:0] PMIN = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nlat_q, nlat_d;
  logic [CNT_W-1:0] pts_cl;
  logic [channels-1:0][W-1:0] fmax_q, fmax_d;
  logic [channels-1:0][W-1:0] fmin_q, fmin_d;
  logic [channels-1:0][W-1:0] pmax_q, pmax_d;
  logic [channels-1:0][W-1:0] pmin_q, pmin_d;
  logic [channels-1:0][W:0]   pvpp_q, pvpp_d;
  logic done_q, done_d;
  logic irq_q, irq_d;
`ifdef VPP_MEAN_EN
  logic [channels-1:0][SW-1:0] facc_q, facc_d;
  logic [channels-1:0][SW-1:0] psum_q, psum_d;
`endif

  function automatic logic [W:0] ext(input logic [W-1:0] x);
    return signed_mode ? {x[W-1], x} : {1'b0, x};
  endfunction

  function automatic logic gt(input logic [W-1:0] a,
                              input logic [W-1:0] b);
    return $signed(ext(a)) > $signed(ext(b));
  endfunction

`ifdef VPP_MEAN_EN
  function automatic logic [SW-1:0] sext(input logic [W-1:0] x);
    return signed_mode ? {{CNT_W{x[W-1]}}, x} : {{CNT_W{1'b0}}, x};
  endfunction
`endif

  always_comb begin
    pts_cl = points;
    if (points < PMIN) pts_cl = PMIN;
    else if (points > PMAX) pts_cl = PMAX;
  end

  always_comb begin
    cnt_d  = cnt_q;
    nlat_d = nlat_q;
    fmax_d = fmax_q;
    fmin_d = fmin_q;
    pmax_d = pmax_q;
    pmin_d = pmin_q;
    pvpp_d = pvpp_q;
    done_d = 1'b0;
`ifdef VPP_MEAN_EN
    facc_d = facc_q;
    psum_d = psum_q;
`endif
    if (clear) begin
      cnt_d = '0;
`ifdef VPP_MEAN_EN
      facc_d = '0;
`endif
    end else if (data_valid) begin
      for (int k = 0; k < channels; k++) begin
        if (cnt_q == '0) begin
          fmax_d[k] = data_u[k*W +: W];
          fmin_d[k] = data_u[k*W +: W];
`ifdef VPP_MEAN_EN
          facc_d[k] = sext(data_u[k*W +: W]);
`endif
        end else begin
          if (gt(data_u[k*W +: W], fmax_q[k]))
            fmax_d[k] = data_u[k*W +: W];
          if (gt(fmin_q[k], data_u[k*W +: W]))
            fmin_d[k] = data_u[k*W +: W];
`ifdef VPP_MEAN_EN
          facc_d[k] = facc_q[k] + sext(data_u[k*W +: W]);
`endif
        end
      end
      // window length is at least 2, so the first sample is never the last
      if (cnt_q == '0) begin
        nlat_d = pts_cl;
        cnt_d  = CNT_W'(1);
      end else if (cnt_q == nlat_q - 1'b1) begin
        cnt_d  = '0;
        done_d = 1'b1;
        pmax_d = fmax_d;
        pmin_d = fmin_d;
        for (int k = 0; k < channels; k++)
          pvpp_d[k] = ext(fmax_d[k]) - ext(fmin_d[k]);
`ifdef VPP_MEAN_EN
        psum_d = facc_d;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    irq_d = done_d | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      nlat_q <= '0;
      fmax_q <= '0;
      fmin_q <= '0;
      pmax_q <= '0;
      pmin_q <= '0;
      pvpp_q <= '0;
      done_q <= 1'b0;
      irq_q  <= 1'b0;
`ifdef VPP_MEAN_EN
      facc_q <= '0;
      psum_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      nlat_q <= nlat_d;
      fmax_q <= fmax_d;
      fmin_q <= fmin_d;
      pmax_q <= pmax_d;
      pmin_q <= pmin_d;
      pvpp_q <= pvpp_d;
      done_q <= done_d;
      irq_q  <= irq_d;
`ifdef VPP_MEAN_EN
      facc_q <= facc_d;
      psum_q <= psum_d;
`endif
    end
  end

  assign max  = pmax_q;
  assign min  = pmin_q;
  assign vpp  = pvpp_q;
  assign done = done_q;
  assign irq  = irq_q;
  assign cnt  = cnt_q;
`ifdef VPP_MEAN_EN
  assign sum  = psum_q;
`endif

endmodule

// File: tb/tb_vpp_multi_ch.sv
// Bench for vpp_multi_ch: unsigned and signed instances, directed + random.
// Random phase uses a queue-based window model per channel.
module tb_vpp_multi_ch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, data_valid, clear, irq_clr;
  logic [23:0] data_u;
  logic [12:0] points;
  logic [23:0] u_max, u_min, s_max, s_min;
  logic [25:0] u_vpp, s_vpp;
  logic        u_done, u_irq, s_done, s_irq;
  logic [12:0] u_cnt, s_cnt;
`ifdef VPP_MEAN_EN
  logic [49:0] u_sum, s_sum;
`endif

  int n_cmp = 0;
  int n_err = 0;

  vpp_multi_ch #(.signed_mode(1'b0)) u_dut (
    .clk_fs(clk), .rst_n(rst_n), .data_valid(data_valid),
    .data_u(data_u), .points(points), .clear(clear),
    .irq_clr(irq_clr), .max(u_max), .min(u_min), .vpp(u_vpp),
`ifdef VPP_MEAN_EN
    .sum(u_sum),
`endif
    .done(u_done), .irq(u_irq), .cnt(u_cnt)
  );

  vpp_multi_ch #(.signed_mode(1'b1)) s_dut (
    .clk_fs(clk), .rst_n(rst_n), .data_valid(data_valid),
    .data_u(data_u), .points(points), .clear(clear),
    .irq_clr(irq_clr), .max(s_max), .min(s_min), .vpp(s_vpp),
`ifdef VPP_MEAN_EN
    .sum(s_sum),
`endif
    .done(s_done), .irq(s_irq), .cnt(s_cnt)
  );

  task automatic step(input logic v, input int d0, input int d1,
                      input int p, input logic clr, input logic ic);
    data_valid = v;
    data_u     = {12'(d1), 12'(d0)};
    points     = 13'(p);
    clear      = clr;
    irq_clr    = ic;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    clear      = 1'b0;
    irq_clr    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    data_valid = 1'b0; clear = 1'b0; irq_clr = 1'b0;
    data_u = '0; points = 13'd4;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (u_max !== 0 || u_min !== 0 || u_vpp !== 0) begin
      n_err++;
      $display("FAIL reset_u_out got %h/%h/%h want 0", u_max, u_min, u_vpp);
    end
    n_cmp++;
    if (u_done !== 0 || u_irq !== 0 || u_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_u_ctl got %b/%b/%0d want 0", u_done, u_irq, u_cnt);
    end
    n_cmp++;
    if (s_max !== 0 || s_vpp !== 0 || s_cnt !== 0 || s_irq !== 0) begin
      n_err++;
      $display("FAIL reset_s got %h/%h/%0d/%b want 0", s_max, s_vpp, s_cnt, s_irq);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    step(1, 5, 3, 4, 0, 0);
    step(1, 9, 3, 4, 0, 0);
    step(1, 1, 3, 4, 0, 0);
    n_cmp++;
    if (u_done !== 0 || u_cnt !== 13'd3) begin
      n_err++;
      $display("FAIL basic_mid got done=%b cnt=%0d want 0/3", u_done, u_cnt);
    end
    step(1, 7, 3, 4, 0, 0);
    n_cmp++;
    if (u_done !== 1 || u_cnt !== 0 || u_irq !== 1) begin
      n_err++;
      $display("FAIL basic_done got done=%b cnt=%0d irq=%b want 1/0/1", u_done, u_cnt, u_irq);
    end
    n_cmp++;
    if (u_max[11:0] !== 12'd9 || u_min[11:0] !== 12'd1 || u_vpp[12:0] !== 13'd8) begin
      n_err++;
      $display("FAIL basic_ch0 got %0d/%0d/%0d want 9/1/8", u_max[11:0], u_min[11:0], u_vpp[12:0]);
    end
    n_cmp++;
    if (u_max[23:12] !== 12'd3 || u_min[23:12] !== 12'd3 || u_vpp[25:13] !== 13'd0) begin
      n_err++;
      $display("FAIL basic_ch1 got %0d/%0d/%0d want 3/3/0", u_max[23:12], u_min[23:12], u_vpp[25:13]);
    end
    step(0, 0, 0, 4, 0, 0);
    n_cmp++;
    if (u_done !== 0 || u_irq !== 1) begin
      n_err++;
      $display("FAIL basic_pulse got done=%b irq=%b want 0/1", u_done, u_irq);
    end
    step(0, 0, 0, 4, 0, 1);
    n_cmp++;
    if (u_irq !== 0) begin
      n_err++;
      $display("FAIL basic_irqclr got %b want 0", u_irq);
    end
  endtask

  task automatic test_last_fold();
    step(1, 2, 0, 4, 0, 0);
    step(1, 2, 0, 4, 0, 0);
    step(1, 2, 0, 4, 0, 0);
    step(1, 4095, 0, 4, 0, 0);
    n_cmp++;
    if (u_done !== 1 || u_max[11:0] !== 12'd4095 || u_vpp[12:0] !== 13'd4093) begin
      n_err++;
      $display("FAIL last_fold got done=%b max=%0d vpp=%0d want 1/4095/4093", u_done, u_max[11:0], u_vpp[12:0]);
    end
  endtask

  task automatic test_gaps();
    int dat[5] = '{10, 0, 20, 0, 15};
    int ecnt[5] = '{1, 1, 2, 2, 0};
    for (int i = 0; i < 5; i++) begin
      step((i % 2) == 0, dat[i], 0, 3, 0, 0);
      n_cmp++;
      if (u_cnt !== 13'(ecnt[i]) || u_done !== (i == 4)) begin
        n_err++;
        $display("FAIL gaps_%0d got cnt=%0d done=%b want %0d/%b", i, u_cnt, u_done, ecnt[i], i == 4);
      end
    end
    n_cmp++;
    if (u_max[11:0] !== 12'd20 || u_min[11:0] !== 12'd10 || u_vpp[12:0] !== 13'd10) begin
      n_err++;
      $display("FAIL gaps_res got %0d/%0d/%0d want 20/10/10", u_max[11:0], u_min[11:0], u_vpp[12:0]);
    end
  endtask

  task automatic test_signed();
    step(1, 12'h800, 0, 2, 0, 0);
    step(1, 12'h7FF, 0, 2, 0, 0);
    n_cmp++;
    if (s_done !== 1 || s_max[11:0] !== 12'h7FF || s_min[11:0] !== 12'h800 || s_vpp[12:0] !== 13'd4095) begin
      n_err++;
      $display("FAIL signed_res got done=%b %h/%h/%0d want 1/7ff/800/4095", s_done, s_max[11:0], s_min[11:0], s_vpp[12:0]);
    end
    n_cmp++;
    if (u_max[11:0] !== 12'h800 || u_min[11:0] !== 12'h7FF || u_vpp[12:0] !== 13'd1) begin
      n_err++;
      $display("FAIL unsigned_res got %h/%h/%0d want 800/7ff/1", u_max[11:0], u_min[11:0], u_vpp[12:0]);
    end
  endtask

  task automatic test_points();
    step(1, 8, 0, 0, 0, 0);
    step(1, 6, 0, 0, 0, 0);
    n_cmp++;
    if (u_done !== 1 || u_vpp[12:0] !== 13'd2) begin
      n_err++;
      $display("FAIL points_min got done=%b vpp=%0d want 1/2", u_done, u_vpp[12:0]);
    end
    step(1, 50, 0, 4, 0, 0);
    step(1, 60, 0, 4, 0, 0);
    step(1, 70, 0, 8, 0, 0);
    n_cmp++;
    if (u_done !== 0 || u_cnt !== 13'd3) begin
      n_err++;
      $display("FAIL points_chg_mid got done=%b cnt=%0d want 0/3", u_done, u_cnt);
    end
    step(1, 80, 0, 8, 0, 0);
    n_cmp++;
    if (u_done !== 1 || u_cnt !== 0 || u_max[11:0] !== 12'd80) begin
      n_err++;
      $display("FAIL points_chg_end got done=%b cnt=%0d max=%0d want 1/0/80", u_done, u_cnt, u_max[11:0]);
    end
  endtask

  task automatic test_clear();
    step(1, 30, 0, 2, 0, 0);
    step(1, 40, 0, 2, 0, 0);
    step(1, 100, 0, 2, 0, 0);
    step(1, 200, 0, 2, 1, 1);
    n_cmp++;
    if (u_done !== 0 || u_irq !== 0 || u_cnt !== 0) begin
      n_err++;
      $display("FAIL clear_ctl got done=%b irq=%b cnt=%0d want 0/0/0", u_done, u_irq, u_cnt);
    end
    n_cmp++;
    if (u_max[11:0] !== 12'd40 || u_min[11:0] !== 12'd30 || u_vpp[12:0] !== 13'd10) begin
      n_err++;
      $display("FAIL clear_keep got %0d/%0d/%0d want 40/30/10", u_max[11:0], u_min[11:0], u_vpp[12:0]);
    end
    for (int i = 1; i <= 4; i++) step(1, i, 0, 4, 0, 0);
    n_cmp++;
    if (u_done !== 1 || u_max[11:0] !== 12'd4 || u_min[11:0] !== 12'd1) begin
      n_err++;
      $display("FAIL clear_next got done=%b %0d/%0d want 1/4/1", u_done, u_max[11:0], u_min[11:0]);
    end
`ifdef VPP_MEAN_EN
    n_cmp++;
    if (u_sum[24:0] !== 25'd10 || s_sum[24:0] !== 25'd10) begin
      n_err++;
      $display("FAIL mean_sum got %0d/%0d want 10", u_sum[24:0], s_sum[24:0]);
    end
`endif
  endtask

  task automatic test_async_reset();
    step(1, 300, 0, 4, 0, 0);
    step(1, 900, 0, 4, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (u_cnt !== 0 || u_max !== 0 || u_irq !== 0 || u_done !== 0) begin
      n_err++;
      $display("FAIL async_rst got cnt=%0d max=%h irq=%b want 0", u_cnt, u_max, u_irq);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic int sx(input int v);
    return (v >= 2048) ? v - 4096 : v;
  endfunction

  function automatic int pick();
    int r = $urandom_range(0, 7);
    case (r)
      0: return 0;
      1: return 4095;
      2: return 2048;
      3: return 2047;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic test_random();
    int m_cnt = 0, m_n = 2;
    int q[2][$];
    int eu_max[2], eu_min[2], es_max[2], es_min[2];
    logic e_done, e_irq;
    int p, d[2];
    logic v, clr, ic;
    e_irq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      eu_max[k] = 0; eu_min[k] = 0; es_max[k] = 0; es_min[k] = 0;
    end
    do_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v   = ($urandom_range(0, 9) < 7);
      d[0] = pick();
      d[1] = pick();
      p   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1))
                                         : int'($urandom_range(2, 9));
      clr = ($urandom_range(0, 39) == 0);
      ic  = ($urandom_range(0, 9) == 0);
      step(v, d[0], d[1], p, clr, ic);
      e_done = 1'b0;
      if (clr) begin
        m_cnt = 0;
        q[0].delete(); q[1].delete();
      end else if (v) begin
        if (m_cnt == 0) m_n = (p < 2) ? 2 : p;
        for (int k = 0; k < 2; k++) q[k].push_back(d[k]);
        m_cnt++;
        if (m_cnt == m_n) begin
          for (int k = 0; k < 2; k++) begin
            eu_max[k] = q[k][0]; eu_min[k] = q[k][0];
            es_max[k] = sx(q[k][0]); es_min[k] = sx(q[k][0]);
            foreach (q[k][j]) begin
              if (q[k][j] > eu_max[k]) eu_max[k] = q[k][j];
              if (q[k][j] < eu_min[k]) eu_min[k] = q[k][j];
              if (sx(q[k][j]) > es_max[k]) es_max[k] = sx(q[k][j]);
              if (sx(q[k][j]) < es_min[k]) es_min[k] = sx(q[k][j]);
            end
            q[k].delete();
          end
          e_done = 1'b1;
          m_cnt = 0;
        end
      end
      e_irq = e_done ? 1'b1 : (ic ? 1'b0 : e_irq);
      n_cmp++;
      if (u_done !== e_done || s_done !== e_done || u_irq !== e_irq || s_irq !== e_irq) begin
        n_err++;
        $display("FAIL rnd_ctl cyc=%0d got done=%b/%b irq=%b/%b want %b/%b", cyc, u_done, s_done, u_irq, s_irq, e_done, e_irq);
      end
      n_cmp++;
      if (u_cnt !== 13'(m_cnt) || s_cnt !== 13'(m_cnt)) begin
        n_err++;
        $display("FAIL rnd_cnt cyc=%0d got %0d/%0d want %0d", cyc, u_cnt, s_cnt, m_cnt);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (u_max[k*12 +: 12] !== 12'(eu_max[k]) || u_min[k*12 +: 12] !== 12'(eu_min[k]) ||
            u_vpp[k*13 +: 13] !== 13'(eu_max[k] - eu_min[k])) begin
          n_err++;
          $display("FAIL rnd_u ch%0d cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d", k, cyc,
                   u_max[k*12 +: 12], u_min[k*12 +: 12], u_vpp[k*13 +: 13],
                   eu_max[k], eu_min[k], eu_max[k] - eu_min[k]);
        end
        n_cmp++;
        if (s_max[k*12 +: 12] !== 12'(es_max[k]) || s_min[k*12 +: 12] !== 12'(es_min[k]) ||
            s_vpp[k*13 +: 13] !== 13'(es_max[k] - es_min[k])) begin
          n_err++;
          $display("FAIL rnd_s ch%0d cyc=%0d got %h/%h/%0d want %0d/%0d/%0d", k, cyc,
                   s_max[k*12 +: 12], s_min[k*12 +: 12], s_vpp[k*13 +: 13],
                   es_max[k], es_min[k], es_max[k] - es_min[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_fold();
    test_gaps();
    test_signed();
    test_points();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
